// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one outstanding
// instruction-bus request at a time and buffers one returned word for decode.
module fetch_ctrl #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_excep
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        DISCARD = 3'd2,
        HOLD    = 3'd3,
        EXC     = 3'd4,
        WAIT    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_q, req_d;
    logic [31:0] buf_q, buf_d;

    logic        redir_mis;
    logic [63:0] pc_inc;
    logic [63:0] disc_tgt;

    assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign pc_inc    = pc_q + 64'd4;
    // Where a discarded request resumes: a same-cycle redirect wins over the stored target.
    assign disc_tgt  = redirect_valid ? redirect_pc : pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= PC_RESET;
            req_q   <= PC_RESET;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        buf_d   = buf_q;

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (redir_mis) begin
                        state_d = EXC;
                    end else begin
                        req_d   = redirect_pc;
                        state_d = REQ;
                    end
                end else begin
                    req_d   = pc_q;
                    state_d = REQ;
                end
            end

            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (iresp_data_ok) begin
                        // Response closes the old request, so the new target can go out directly.
                        if (redir_mis) begin
                            state_d = EXC;
                        end else begin
                            req_d = redirect_pc;
                        end
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (iresp_data_ok) begin
                    buf_d   = iresp_data;
                    state_d = HOLD;
                end
            end

            DISCARD: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (iresp_data_ok) begin
                    if (disc_tgt[1:0] != 2'b00) begin
                        state_d = EXC;
                    end else begin
                        req_d   = disc_tgt;
                        state_d = REQ;
                    end
                end
            end

            HOLD, EXC, WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (redir_mis) begin
                        state_d = EXC;
                    end else begin
                        req_d   = redirect_pc;
                        state_d = REQ;
                    end
                end else if (!stall && state_q == HOLD) begin
                    pc_d    = pc_inc;
                    req_d   = pc_inc;
                    state_d = REQ;
                end else if (!stall && state_q == EXC) begin
                    state_d = WAIT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ireq_valid = (state_q == REQ) || (state_q == DISCARD);
    assign ireq_addr  = req_q;
    assign out_valid  = (state_q == HOLD) || (state_q == EXC);
    assign out_pc     = pc_q;
    assign out_instr  = (state_q == HOLD) ? buf_q : 32'd0;
    assign out_excep  = (state_q == EXC);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a slot/request-level reference model checked
// every cycle, plus literal expectations along the directed scenarios.
module tb_fetch_ctrl;

    localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_excep;

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(.PC_RESET(PC_RST)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_excep(out_excep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks "a request is on the bus", "that request is stale",
    // "an instruction slot is held", "an exception slot is held", and the one-cycle start-up gap.
    bit          m_ok = 0;
    bit          m_first, m_req, m_stale, m_slot, m_exc;
    logic [63:0] m_pc, m_addr, m_tgt;
    logic [31:0] m_buf;

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1; m_first = 1; m_req = 0; m_stale = 0; m_slot = 0; m_exc = 0;
            m_pc = PC_RST; m_addr = PC_RST; m_buf = 32'd0;
        end else if (m_ok) begin
            if (m_first) begin
                m_first = 0;
                m_tgt = redirect_valid ? redirect_pc : m_pc;
                m_pc  = m_tgt;
                if (m_tgt[1:0] != 0) m_exc = 1;
                else begin m_req = 1; m_addr = m_tgt; end
            end else if (m_req && !m_stale) begin
                if (redirect_valid) begin
                    m_pc = redirect_pc;
                    if (!iresp_data_ok) m_stale = 1;
                    else if (redirect_pc[1:0] != 0) begin m_req = 0; m_exc = 1; end
                    else m_addr = redirect_pc;
                end else if (iresp_data_ok) begin
                    m_buf = iresp_data; m_req = 0; m_slot = 1;
                end
            end else if (m_req) begin
                if (redirect_valid) m_pc = redirect_pc;
                if (iresp_data_ok) begin
                    m_stale = 0;
                    if (m_pc[1:0] != 0) begin m_req = 0; m_exc = 1; end
                    else m_addr = m_pc;
                end
            end else if (redirect_valid) begin
                m_slot = 0; m_exc = 0; m_pc = redirect_pc;
                if (redirect_pc[1:0] != 0) m_exc = 1;
                else begin m_req = 1; m_addr = redirect_pc; end
            end else if (!stall && m_slot) begin
                m_slot = 0; m_pc = m_pc + 64'd4; m_addr = m_pc; m_req = 1;
            end else if (!stall && m_exc) begin
                m_exc = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_ireq_valid", {63'd0, ireq_valid}, {63'd0, m_req});
            chk("m_ireq_addr", ireq_addr, m_addr);
            chk("m_out_valid", {63'd0, out_valid}, {63'd0, (m_slot | m_exc)});
            chk("m_out_pc", out_pc, m_pc);
            chk("m_out_instr", {32'd0, out_instr}, {32'd0, (m_slot ? m_buf : 32'd0)});
            chk("m_out_excep", {63'd0, out_excep}, {63'd0, m_exc});
        end
    end

    task automatic cyc(input logic r, input logic d, input logic [31:0] dat,
                       input logic rv, input logic [63:0] rpc, input logic st);
        reset = r; iresp_data_ok = d; iresp_data = dat;
        redirect_valid = rv; redirect_pc = rpc; stall = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input logic st);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, st);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 10 && !ireq_valid; i++) idle_cyc(1'b0);
        chk("req_up", {63'd0, ireq_valid}, 64'd1);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("rst_ireq_addr", ireq_addr, PC_RST);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_pc", out_pc, PC_RST);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_out_excep", {63'd0, out_excep}, 64'd0);

        // Sequential fetch with a zero-wait bus; the second slot is then stalled.
        idle_cyc(1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_req();
            chk("seq_addr", ireq_addr, PC_RST + 64'(4 * k));
            cyc(1'b0, 1'b1, 32'h0000_0013, 1'b0, 64'd0, 1'b1);
            chk("seq_out_valid", {63'd0, out_valid}, 64'd1);
            chk("seq_out_pc", out_pc, PC_RST + 64'(4 * k));
            chk("seq_out_instr", {32'd0, out_instr}, 64'h13);
            if (k == 0) idle_cyc(1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            idle_cyc(1'b1);
            chk("stall_out_pc", out_pc, 64'h8000_0004);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_no_req", {63'd0, ireq_valid}, 64'd0);
        end
        idle_cyc(1'b0);
        chk("after_stall_addr", ireq_addr, 64'h8000_0008);
        chk("after_stall_req", {63'd0, ireq_valid}, 64'd1);

        // Redirect while a request is outstanding; its late response is discarded.
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 64'h8000_1000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("discard_addr_stable", ireq_addr, 64'h8000_0008);
            if (i < 2) idle_cyc(1'b0);
        end
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'd0, 1'b0);
        chk("discard_no_out", {63'd0, out_valid}, 64'd0);
        chk("discard_next_addr", ireq_addr, 64'h8000_1000);

        // Redirect coinciding with a response in REQ.
        cyc(1'b0, 1'b1, 32'h1111_1111, 1'b1, 64'h8000_2000, 1'b0);
        chk("same_cyc_addr", ireq_addr, 64'h8000_2000);
        chk("same_cyc_no_out", {63'd0, out_valid}, 64'd0);
        cyc(1'b0, 1'b1, 32'h0010_0093, 1'b0, 64'd0, 1'b1);
        chk("same_cyc_instr", {32'd0, out_instr}, 64'h0010_0093);

        // Misaligned redirect from HOLD, then idle until a good redirect.
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 64'h8000_0102, 1'b1);
        chk("exc_valid", {63'd0, out_valid}, 64'd1);
        chk("exc_flag", {63'd0, out_excep}, 64'd1);
        chk("exc_pc", out_pc, 64'h8000_0102);
        chk("exc_instr", {32'd0, out_instr}, 64'd0);
        chk("exc_no_req", {63'd0, ireq_valid}, 64'd0);
        idle_cyc(1'b0);
        chk("wait_no_out", {63'd0, out_valid}, 64'd0);
        idle_cyc(1'b0);
        idle_cyc(1'b0);
        chk("wait_no_req", {63'd0, ireq_valid}, 64'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 64'h8000_0200, 1'b0);
        chk("resume_addr", ireq_addr, 64'h8000_0200);

        // Reset while discarding, with a response in the same cycle.
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 64'h8000_0300, 1'b0);
        cyc(1'b1, 1'b1, 32'h2222_2222, 1'b0, 64'd0, 1'b0);
        chk("rst2_req", {63'd0, ireq_valid}, 64'd0);
        chk("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst2_out_pc", out_pc, PC_RST);
        idle_cyc(1'b0);
        chk("rst2_first_addr", ireq_addr, PC_RST);

        // Redirect taken in IDLE, then PC wrap at the top of the address space.
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 64'h8000_4000, 1'b0);
        chk("idle_redir_addr", ireq_addr, 64'h8000_4000);
        cyc(1'b0, 1'b1, 32'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        chk("top_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b0, 1'b1, 32'h0000_0073, 1'b0, 64'd0, 1'b0);
        chk("top_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        idle_cyc(1'b0);
        chk("wrap_addr", ireq_addr, 64'd0);

        // Misaligned target reached through DISCARD.
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 64'h0000_0000_0000_0006, 1'b0);
        chk("mis_disc_addr", ireq_addr, 64'd0);
        cyc(1'b0, 1'b1, 32'h3333_3333, 1'b0, 64'd0, 1'b1);
        chk("mis_disc_exc", {63'd0, out_excep}, 64'd1);
        chk("mis_disc_pc", out_pc, 64'h6);
        chk("mis_disc_no_req", {63'd0, ireq_valid}, 64'd0);
        idle_cyc(1'b0);
        idle_cyc(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
